ex_mem_stage: RTL and testbench
===============================

Name: ex_mem_stage

Overview:
Execute stage plus EX/MEM pipeline register for the 5-stage MIPS pipeline. Consumes the ID/EX register outputs (control, RD1E/RD2E, RsE/RtE/RdE, SignImmE) and selects forwarded operands. Computes the ALU result and latches everything the MEM stage needs. Also exports the combinational destination register WriteRegE to the hazard unit.

Parameters:
WIDTH, 32, datapath width
REGW, 5, register-index width

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-low reset
RegWriteE, MemtoRegE, MemWriteE, AluSrcE, RegDstE  in  1 each  control from ID/EX
AluControlE  in  3  ALU operation
RD1E, RD2E  in  WIDTH  register-file operands
SignImmE  in  WIDTH  sign-extended immediate
RtE, RdE  in  REGW  destination candidates
ForwardAE, ForwardBE  in  2  forward selects from hazard unit
ResultW  in  WIDTH  writeback-stage result
stallM  in  1  hold EX/MEM register
flushM  in  1  insert bubble into EX/MEM
WriteRegE  out  REGW  combinational destination (RegDstE ? RdE : RtE)
RegWriteM, MemtoRegM, MemWriteM  out  1 each  registered control
ALUOutM  out  WIDTH  registered ALU result; also the internal forward source
WriteDataM  out  WIDTH  registered store data (forwarded B before immediate mux)
WriteRegM  out  REGW  registered destination
ZeroM  out  1  registered (ALU result == 0)

Behaviour:
- Forward mux A/B: 00 -> RD1E/RD2E; 01 -> ResultW; 10 -> ALUOutM (the current registered value); 11 -> same as 00.
- SrcBE = AluSrcE ? SignImmE : forwarded B. WriteDataE = forwarded B.
- ALU, WIDTH-bit, results wrap modulo 2^WIDTH:
  - 010 ADD, 110 SUB, 000 AND, 001 OR.
  - 111 SLT: signed compare; result is 1 or 0, zero-extended.
  - 011/100/101: result 0.
- Zero = (ALU result == 0).
- EX/MEM register update, at each rising clk edge, priority order:
  1. reset==0: all registered outputs cleared to 0 (RegWriteM=MemtoRegM=MemWriteM=0, ALUOutM=WriteDataM=0, WriteRegM=0, ZeroM=0).
  2. flushM==1: same zero/bubble values as reset. flushM beats stallM.
  3. stallM==1: all registered outputs hold.
  4. Otherwise: load the EX values.
- Latency: one cycle from E inputs to M outputs. WriteRegE has zero latency.
- Forward select 10 while stallM holds: uses the held ALUOutM value.
- Reset asserted mid-stall clears the register. The first edge after reset deasserts loads normally.
- A bubble (flush or reset) never writes memory or the register file, because MemWriteM=RegWriteM=0.

Optional Feature:
EX_OVF_TRAP_EN.
- Defined:
  - Adds output port OverflowM (1 bit, registered; cleared by reset, flush and bubble; held on stall).
  - Signed overflow on ADD or SUB sets OverflowM=1 and forces RegWriteM=0 for that instruction. All other fields load normally.
  - SLT/logic operations never flag overflow.
- Undefined: no OverflowM port; overflow silently wraps; RegWriteM follows RegWriteE.

Test Plan:
- Reset: reset=0 for 2 cycles with nonzero inputs -> all M outputs 0; reset=1, ADD RD1E=5 RD2E=7 RdE=3 RegDstE=1 RegWriteE=1 -> next edge ALUOutM=12, WriteRegM=3, RegWriteM=1, ZeroM=0.
- Forwarding: ForwardAE=10 with ALUOutM=12, ForwardBE=01 with ResultW=30, SUB -> ALUOutM=0xFFFFFFEE. Then ForwardAE=11 with RD1E=9, RD2E=9, SUB -> ALUOutM=0, ZeroM=1.
- Immediate and store: AluSrcE=1, SignImmE=0xFFFFFFFC, RD1E=0x100, RD2E=0xAB, MemWriteE=1, ADD -> ALUOutM=0xFC, WriteDataM=0xAB, MemWriteM=1.
- SLT signed: RD1E=0xFFFFFFFF, RD2E=1 -> ALUOutM=1. Swapped operands -> ALUOutM=0. AluControlE=100 -> ALUOutM=0, ZeroM=1.
- Stall/flush: stallM=1 for 3 cycles while inputs change -> M outputs unchanged. stallM=1 and flushM=1 together -> all M outputs 0.
- (EX_OVF_TRAP_EN) ADD 0x7FFFFFFF+1 with RegWriteE=1 -> ALUOutM=0x80000000, OverflowM=1, RegWriteM=0. Without macro: same ALUOutM, RegWriteM=1.

Source files
------------

// File: rtl/ex_mem_stage.sv
// ex_mem_stage: execute stage plus EX/MEM pipeline register.
// This block selects the forwarded operands, runs the ALU and latches everything
// the MEM stage needs. It also drives the combinational destination WriteRegE to
// the hazard unit.
// Optional feature: define EX_OVF_TRAP_EN to add the OverflowM port. With it, a
// signed overflow on ADD or SUB suppresses the register write of that instruction.
module ex_mem_stage #(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteE,
  input  logic             MemtoRegE,
  input  logic             MemWriteE,
  input  logic             AluSrcE,
  input  logic             RegDstE,
  input  logic [2:0]       AluControlE,
  input  logic [WIDTH-1:0] RD1E,
  input  logic [WIDTH-1:0] RD2E,
  input  logic [WIDTH-1:0] SignImmE,
  input  logic [REGW-1:0]  RtE,
  input  logic [REGW-1:0]  RdE,
  input  logic [1:0]       ForwardAE,
  input  logic [1:0]       ForwardBE,
  input  logic [WIDTH-1:0] ResultW,
  input  logic             stallM,
  input  logic             flushM,
  output logic [REGW-1:0]  WriteRegE,
  output logic             RegWriteM,
  output logic             MemtoRegM,
  output logic             MemWriteM,
  output logic [WIDTH-1:0] ALUOutM,
  output logic [WIDTH-1:0] WriteDataM,
  output logic [REGW-1:0]  WriteRegM,
`ifdef EX_OVF_TRAP_EN
  output logic             OverflowM,
`endif
  output logic             ZeroM
);

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  logic [WIDTH-1:0] src_a, fwd_b, src_b, alu_res;
  logic             alu_zero;

  logic             reg_write_q, reg_write_d;
  logic             mem_to_reg_q, mem_to_reg_d;
  logic             mem_write_q, mem_write_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d;
  logic [WIDTH-1:0] write_data_q, write_data_d;
  logic [REGW-1:0]  write_reg_q, write_reg_d;
  logic             zero_q, zero_d;
`ifdef EX_OVF_TRAP_EN
  logic             ovf, ovf_q, ovf_d;
`endif

  assign WriteRegE = RegDstE ? RdE : RtE;

  // Operand forwarding; select 10 uses whatever ALUOutM currently holds, including during a stall.
  always_comb begin
    src_a = RD1E;
    fwd_b = RD2E;
    case (ForwardAE)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = alu_out_q;
      default: src_a = RD1E;
    endcase
    case (ForwardBE)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = alu_out_q;
      default: fwd_b = RD2E;
    endcase
    src_b = AluSrcE ? SignImmE : fwd_b;
  end

  // ALU: arithmetic wraps; unused opcodes produce zero.
  always_comb begin
    alu_res = '0;
    case (AluControlE)
      OP_ADD:  alu_res = src_a + src_b;
      OP_SUB:  alu_res = src_a - src_b;
      OP_AND:  alu_res = src_a & src_b;
      OP_OR:   alu_res = src_a | src_b;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      default: alu_res = '0;
    endcase
  end

  assign alu_zero = (alu_res == '0);

`ifdef EX_OVF_TRAP_EN
  // Signed overflow: operands effectively share a sign and the result sign differs.
  always_comb begin
    ovf = 1'b0;
    case (AluControlE)
      OP_ADD:  ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
      OP_SUB:  ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (alu_res[WIDTH-1] != src_a[WIDTH-1]);
      default: ovf = 1'b0;
    endcase
  end
`endif

  // Values presented to the EX/MEM register on a normal load.
  always_comb begin
    reg_write_d  = RegWriteE;
    mem_to_reg_d = MemtoRegE;
    mem_write_d  = MemWriteE;
    alu_out_d    = alu_res;
    write_data_d = fwd_b;
    write_reg_d  = WriteRegE;
    zero_d       = alu_zero;
`ifdef EX_OVF_TRAP_EN
    ovf_d        = ovf;
    if (ovf) reg_write_d = 1'b0;
`endif
  end

  // EX/MEM register: reset, then flush (bubble), then stall (hold), else load.
  always_ff @(posedge clk) begin
    if (!reset || flushM) begin
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_out_q    <= '0;
      write_data_q <= '0;
      write_reg_q  <= '0;
      zero_q       <= 1'b0;
`ifdef EX_OVF_TRAP_EN
      ovf_q        <= 1'b0;
`endif
    end else if (!stallM) begin
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      alu_out_q    <= alu_out_d;
      write_data_q <= write_data_d;
      write_reg_q  <= write_reg_d;
      zero_q       <= zero_d;
`ifdef EX_OVF_TRAP_EN
      ovf_q        <= ovf_d;
`endif
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemtoRegM  = mem_to_reg_q;
  assign MemWriteM  = mem_write_q;
  assign ALUOutM    = alu_out_q;
  assign WriteDataM = write_data_q;
  assign WriteRegM  = write_reg_q;
  assign ZeroM      = zero_q;
`ifdef EX_OVF_TRAP_EN
  assign OverflowM  = ovf_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb_ex_mem_stage: directed plus randomized bench for ex_mem_stage.
// A behavioural model tracks the M-stage contents and is compared every cycle.
// Follows EX_OVF_TRAP_EN when defined.
module tb_ex_mem_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        RegWriteE, MemtoRegE, MemWriteE, AluSrcE, RegDstE;
  logic [2:0]  AluControlE;
  logic [31:0] RD1E, RD2E, SignImmE, ResultW;
  logic [4:0]  RtE, RdE;
  logic [1:0]  ForwardAE, ForwardBE;
  logic        stallM, flushM;
  logic [4:0]  WriteRegE, WriteRegM;
  logic        RegWriteM, MemtoRegM, MemWriteM, ZeroM;
  logic [31:0] ALUOutM, WriteDataM;
`ifdef EX_OVF_TRAP_EN
  logic        OverflowM;
`endif

  ex_mem_stage #(.WIDTH(32), .REGW(5)) dut (
    .clk(clk), .reset(reset),
    .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .MemWriteE(MemWriteE),
    .AluSrcE(AluSrcE), .RegDstE(RegDstE), .AluControlE(AluControlE),
    .RD1E(RD1E), .RD2E(RD2E), .SignImmE(SignImmE), .RtE(RtE), .RdE(RdE),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .ResultW(ResultW),
    .stallM(stallM), .flushM(flushM), .WriteRegE(WriteRegE),
    .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM),
    .ALUOutM(ALUOutM), .WriteDataM(WriteDataM), .WriteRegM(WriteRegM),
`ifdef EX_OVF_TRAP_EN
    .OverflowM(OverflowM),
`endif
    .ZeroM(ZeroM)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  logic        m_rw, m_mtr, m_mw, m_zero, m_ovf;
  logic [31:0] m_alu, m_wd;
  logic [4:0]  m_wr;
  bit          model_valid = 0;
  bit          ovf_trap;

  initial begin
`ifdef EX_OVF_TRAP_EN
    ovf_trap = 1;
`else
    ovf_trap = 0;
`endif
  end

  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'b010:  return 32'(sa + sb);
      3'b110:  return 32'(sa - sb);
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b111:  return (sa < sb) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_ovf(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint r;
    if (op == 3'b010)      r = longint'($signed(a)) + longint'($signed(b));
    else if (op == 3'b110) r = longint'($signed(a)) - longint'($signed(b));
    else return 0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction

  always @(posedge clk) begin
    logic [31:0] a, fb, b, r;
    bit o;
    a  = (ForwardAE == 2'd1) ? ResultW : (ForwardAE == 2'd2) ? m_alu : RD1E;
    fb = (ForwardBE == 2'd1) ? ResultW : (ForwardBE == 2'd2) ? m_alu : RD2E;
    b  = AluSrcE ? SignImmE : fb;
    r  = ref_alu(AluControlE, a, b);
    o  = ovf_trap && ref_ovf(AluControlE, a, b);
    if (!reset || flushM) begin
      {m_rw, m_mtr, m_mw, m_zero, m_ovf} = '0;
      m_alu = 0; m_wd = 0; m_wr = 0;
    end else if (!stallM) begin
      m_rw = RegWriteE && !o; m_mtr = MemtoRegE; m_mw = MemWriteE;
      m_alu = r; m_wd = fb; m_wr = RegDstE ? RdE : RtE;
      m_zero = (r == 0); m_ovf = o;
    end
    model_valid = 1;
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (model_valid) begin
      chk("WriteRegE", 32'(WriteRegE), 32'(RegDstE ? RdE : RtE));
      chk("RegWriteM", 32'(RegWriteM), 32'(m_rw));
      chk("MemtoRegM", 32'(MemtoRegM), 32'(m_mtr));
      chk("MemWriteM", 32'(MemWriteM), 32'(m_mw));
      chk("ALUOutM", ALUOutM, m_alu);
      chk("WriteDataM", WriteDataM, m_wd);
      chk("WriteRegM", 32'(WriteRegM), 32'(m_wr));
      chk("ZeroM", 32'(ZeroM), 32'(m_zero));
`ifdef EX_OVF_TRAP_EN
      chk("OverflowM", 32'(OverflowM), 32'(m_ovf));
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    AluControlE = op; RD1E = a; RD2E = b;
    ForwardAE = 2'b00; ForwardBE = 2'b00; AluSrcE = 0;
  endtask

  task automatic rand_inputs();
    {RegWriteE, MemtoRegE, MemWriteE, AluSrcE, RegDstE} = 5'($urandom);
    AluControlE = 3'($urandom);
    RD1E = $urandom; RD2E = $urandom; SignImmE = $urandom; ResultW = $urandom;
    if ($urandom_range(0, 3) == 0) RD2E = RD1E;
    if ($urandom_range(0, 3) == 0) RD1E = 32'h7FFFFFFF;
    RtE = 5'($urandom); RdE = 5'($urandom);
    ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, " ctrl"}, {29'd0, RegWriteM, MemtoRegM, MemWriteM}, 32'd0);
    chk({tag, " alu"}, ALUOutM, 32'd0);
    chk({tag, " wd"}, WriteDataM, 32'd0);
    chk({tag, " wr/zero"}, {26'd0, WriteRegM, ZeroM}, 32'd0);
  endtask

  initial begin
    reset = 0; stallM = 0; flushM = 0;
    RegWriteE = 1; MemtoRegE = 1; MemWriteE = 1; AluSrcE = 0; RegDstE = 1;
    AluControlE = 3'b010; RD1E = 32'h55; RD2E = 32'h66; SignImmE = 32'h77;
    RtE = 5'd9; RdE = 5'd10; ForwardAE = 0; ForwardBE = 0; ResultW = 32'h88;
    tick(); tick();
    chk_all_zero("reset");

    reset = 1;
    set_op(3'b010, 32'd5, 32'd7); RdE = 5'd3; RtE = 5'd4; RegDstE = 1;
    RegWriteE = 1; MemtoRegE = 0; MemWriteE = 0;
    tick();
    chk("add alu", ALUOutM, 32'd12);
    chk("add wr", 32'(WriteRegM), 32'd3);
    chk("add rw/zero", {30'd0, RegWriteM, ZeroM}, 32'b10);

    set_op(3'b110, 32'h0, 32'h0); ForwardAE = 2'b10; ForwardBE = 2'b01; ResultW = 32'd30;
    tick();
    chk("fwd sub", ALUOutM, 32'hFFFFFFEE);

    set_op(3'b110, 32'd9, 32'd9); ForwardAE = 2'b11;
    tick();
    chk("sub zero", {31'd0, ZeroM}, 32'd1);
    chk("sub zero alu", ALUOutM, 32'd0);

    set_op(3'b010, 32'h100, 32'hAB); AluSrcE = 1; SignImmE = 32'hFFFFFFFC; MemWriteE = 1;
    tick();
    chk("imm alu", ALUOutM, 32'hFC);
    chk("store data", WriteDataM, 32'hAB);
    chk("store mw", 32'(MemWriteM), 32'd1);
    MemWriteE = 0;

    set_op(3'b111, 32'hFFFFFFFF, 32'd1);
    tick(); chk("slt neg", ALUOutM, 32'd1);
    set_op(3'b111, 32'd1, 32'hFFFFFFFF);
    tick(); chk("slt swap", ALUOutM, 32'd0);
    set_op(3'b100, 32'd3, 32'd5);
    tick(); chk("op100", {ALUOutM[30:0], ZeroM}, 32'd1);

    set_op(3'b010, 32'h11, 32'h22);
    tick();
    stallM = 1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      tick();
      chk("stall hold", ALUOutM, 32'h33);
    end
    set_op(3'b010, 32'h0, 32'd1); ForwardAE = 2'b10;
    tick();
    chk("stall fwd", ALUOutM, 32'h33);
    stallM = 0;
    tick();
    chk("post stall fwd", ALUOutM, 32'h34);

    stallM = 1; flushM = 1;
    tick();
    chk_all_zero("flush");
    flushM = 0; stallM = 0;

    set_op(3'b010, 32'h7FFFFFFF, 32'd1); RegWriteE = 1;
    tick();
    chk("ovf alu", ALUOutM, 32'h80000000);
`ifdef EX_OVF_TRAP_EN
    chk("ovf rw", 32'(RegWriteM), 32'd0);
    chk("ovf flag", 32'(OverflowM), 32'd1);
`else
    chk("ovf rw", 32'(RegWriteM), 32'd1);
`endif

    set_op(3'b001, 32'hF0, 32'h0F);
    tick();
    stallM = 1; reset = 0;
    tick();
    chk_all_zero("reset in stall");
    reset = 1; stallM = 0;
    set_op(3'b000, 32'hFF00, 32'h0FF0);
    tick();
    chk("load after reset", ALUOutM, 32'h0F00);

    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      reset  = ($urandom_range(0, 49) != 0);
      flushM = ($urandom_range(0, 9) == 0);
      stallM = ($urandom_range(0, 4) == 0);
      tick();
    end

    reset = 1; stallM = 0; flushM = 0;
    tick(); tick();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
